// File: rtl/branch_resolve_unit.sv
// Purpose : resolves branch/jump ops (condition, target, link) and raises a fetch redirect on predictor mispredict.
// Latency : accept in cycle N -> executed/taken/jump/target/link registered and valid in cycle N+1.
// Backpr. : ready_o low while stalled, flushing or holding a redirect; redirect_o held until redirect_ack_i.
//
// Ports:
//   clk_i, rst_n_i                         clock, async active-low reset
//   stall_i, flush_i                       pipeline stall / flush
//   valid_i, ready_o                       op handshake
//   operation_i, operand_A_i, operand_B_i  op code and rs1/rs2 values
//   instr_address_i, offset_i, compressed_i PC, sign-extended immediate, 16-bit instr flag
//   executed_o, taken_o, jump_o            resolution pulse and outcome
//   target_address_o, link_o               computed target and return address
//   mispredicted_i                         predictor verdict while executed_o high
//   redirect_o, redirect_address_o, redirect_ack_i  fetch redirect handshake
//   mispredict_count_o                     saturating mispredict counter
module branch_resolve_unit (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [2:0]  operation_i,
  input  logic [31:0] operand_A_i,
  input  logic [31:0] operand_B_i,
  input  logic [31:0] instr_address_i,
  input  logic [31:0] offset_i,
  input  logic        compressed_i,
  output logic        executed_o,
  output logic        taken_o,
  output logic        jump_o,
  output logic [31:0] target_address_o,
  output logic [31:0] link_o,
  input  logic        mispredicted_i,
  output logic        redirect_o,
  output logic [31:0] redirect_address_o,
  input  logic        redirect_ack_i,
  output logic [15:0] mispredict_count_o
);

  typedef logic [31:0] data_word_t;

  typedef enum logic {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_JAL  = 3'b010;
  localparam logic [2:0] OP_JALR = 3'b011;
  localparam logic [2:0] OP_BLT  = 3'b100;
  localparam logic [2:0] OP_BGE  = 3'b101;
  localparam logic [2:0] OP_BLTU = 3'b110;
  localparam logic [2:0] OP_BGEU = 3'b111;

  state_t     state_q, state_d;
  logic       executed_q, executed_d;
  logic       taken_q, taken_d;
  logic       jump_q, jump_d;
  data_word_t target_q, target_d;
  data_word_t link_q, link_d;
  data_word_t redirect_addr_q, redirect_addr_d;
  logic [15:0] count_q, count_d;

  logic       accept;
  logic       cond_taken;
  logic       is_jump;
  logic       eq, lt_s, lt_u;
  data_word_t base_sum;
  data_word_t jalr_sum;
  data_word_t fallthrough;
  logic       take_redirect;

  assign ready_o = (state_q == RUN) && !stall_i && !flush_i;
  assign accept  = valid_i && ready_o;

  // Operand comparisons and address arithmetic for the op being presented.
  always_comb begin
    eq          = (operand_A_i == operand_B_i);
    lt_s        = ($signed(operand_A_i) < $signed(operand_B_i));
    lt_u        = (operand_A_i < operand_B_i);
    base_sum    = instr_address_i + offset_i;
    jalr_sum    = operand_A_i + offset_i;
    fallthrough = instr_address_i + (compressed_i ? 32'd2 : 32'd4);
    is_jump     = (operation_i == OP_JAL) || (operation_i == OP_JALR);
    cond_taken  = 1'b0;
    unique case (operation_i)
      OP_BEQ:  cond_taken = eq;
      OP_BNE:  cond_taken = !eq;
      OP_BLT:  cond_taken = lt_s;
      OP_BGE:  cond_taken = !lt_s;
      OP_BLTU: cond_taken = lt_u;
      OP_BGEU: cond_taken = !lt_u;
      default: cond_taken = 1'b0;
    endcase
  end

  // The verdict only counts for a resolution seen in RUN; a flush in the same
  // cycle discards it.
  assign take_redirect = (state_q == RUN) && executed_q && mispredicted_i && !flush_i;

  always_comb begin
    state_d         = state_q;
    redirect_addr_d = redirect_addr_q;
    count_d         = count_q;
    executed_d      = accept;
    taken_d         = taken_q;
    jump_d          = jump_q;
    target_d        = target_q;
    link_d          = link_q;

    if (accept) begin
      taken_d  = cond_taken;
      jump_d   = is_jump;
      target_d = (operation_i == OP_JALR) ? {jalr_sum[31:1], 1'b0} : base_sum;
      link_d   = fallthrough;
    end

    unique case (state_q)
      RUN: begin
        if (take_redirect) begin
          state_d         = REDIRECT;
          // Correct next PC is the target if the branch went, else the
          // fall-through (held in link_q for every op).
          redirect_addr_d = (taken_q || jump_q) ? target_q : link_q;
          if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
          end
        end
      end
      REDIRECT: begin
        if (flush_i || redirect_ack_i) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q         <= RUN;
      executed_q      <= 1'b0;
      taken_q         <= 1'b0;
      jump_q          <= 1'b0;
      target_q        <= '0;
      link_q          <= '0;
      redirect_addr_q <= '0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      executed_q      <= executed_d;
      taken_q         <= taken_d;
      jump_q          <= jump_d;
      target_q        <= target_d;
      link_q          <= link_d;
      redirect_addr_q <= redirect_addr_d;
      count_q         <= count_d;
    end
  end

  assign executed_o         = executed_q;
  assign taken_o            = taken_q;
  assign jump_o             = jump_q;
  assign target_address_o   = target_q;
  assign link_o             = link_q;
  assign redirect_o         = (state_q == REDIRECT);
  assign redirect_address_o = redirect_addr_q;
  assign mispredict_count_o = count_q;

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have no parameters; all addresses and operands are data_word_t (32 bit).
REQ-002 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_n_i  in  1  reset; asynchronous, active-low.
REQ-004 stall_i  in  1  pipeline stall; blocks acceptance of a new branch.
REQ-005 flush_i  in  1  pipeline flush; clears in-flight branch and redirect.
REQ-006 valid_i  in  1  branch/jump operation presented this cycle.
REQ-007 ready_o  out  1  unit accepts valid_i this cycle.
REQ-008 operation_i  in  3  000 BEQ, 001 BNE, 010 JAL, 011 JALR, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
REQ-009 operand_A_i / operand_B_i  in  32 each  rs1 / rs2 values.
REQ-010 instr_address_i  in  32  PC of the branch.
REQ-011 offset_i  in  32  sign-extended immediate.
REQ-012 compressed_i  in  1  instruction is 16-bit.
REQ-013 executed_o  out  1  one-cycle pulse: branch resolved, to predictor executed_i.
REQ-014 taken_o / jump_o  out  1 each  conditional taken / unconditional jump.
REQ-015 target_address_o  out  32  computed target, to predictor exu_address_i.
REQ-016 link_o  out  32  return address for JAL/JALR writeback.
REQ-017 mispredicted_i  in  1  predictor verdict, combinational, valid while executed_o high.
REQ-018 redirect_o  out  1  fetch redirect request, held until acknowledged.
REQ-019 redirect_address_o  out  32  correct next PC; stable while redirect_o high.
REQ-020 redirect_ack_i  in  1  fetch accepted redirect.
REQ-021 mispredict_count_o  out  16  saturating count of mispredictions.

Function
REQ-022 Accept: ready_o = (state == RUN) & !stall_i & !flush_i; accept = valid_i & ready_o.
REQ-023 Latency: accept in cycle N -> executed_o, taken_o, jump_o, target_address_o, link_o registered and valid in cycle N+1.
REQ-024 executed_o SHALL be high exactly one cycle per accepted op; low in any cycle following a non-accepting cycle.
REQ-025 taken_o: BEQ A==B, BNE A!=B, BLT/BGE signed A<B / A>=B, BLTU/BGEU unsigned; 0 for JAL/JALR.
REQ-026 jump_o = 1 for JAL/JALR only.
REQ-027 Target: JALR (A + offset) & ~1; all others PC + offset; modulo 2^32.
REQ-028 Fallthrough = PC + 2 if compressed_i, else PC + 4, modulo 2^32; link_o = fallthrough.
REQ-029 FSM states RUN, REDIRECT; reset state RUN.
REQ-030 RUN -> REDIRECT when executed_o & mispredicted_i & !flush_i; latch redirect_address_o = (taken_o|jump_o) ? target : fallthrough.
REQ-031 redirect_o = (state == REDIRECT); REDIRECT -> RUN on redirect_ack_i (cycle after ack: redirect_o low).
REQ-032 In REDIRECT ready_o is 0; valid_i is ignored.
REQ-033 flush_i: next cycle executed_o = 0, state = RUN, redirect_o = 0; flush wins over simultaneous mispredicted_i and valid_i.
REQ-034 mispredict_count_o increments by 1 on each RUN->REDIRECT transition; saturates at 0xFFFF; unaffected by flush_i.
REQ-035 stall_i high while executed_o is high SHALL NOT extend the pulse.

Reset
REQ-036 On rst_n_i low, immediately: state RUN, executed_o/taken_o/jump_o/redirect_o 0, target_address_o/link_o/redirect_address_o/mispredict_count_o 0.
REQ-037 Reset asserted in REDIRECT SHALL abandon the redirect without waiting for redirect_ack_i.

Verification
REQ-038 BEQ A=5 B=5 PC=0x100 off=0x20, mispredicted_i=0 -> cycle+1 executed_o=1 taken_o=1 target=0x120; no redirect.
REQ-039 BLTU A=0xFFFFFFFF B=1 PC=0x200, predicted taken (mispredicted_i=1) -> taken_o=0, redirect_o=1, redirect_address_o=0x204 held until ack, ready_o=0 meanwhile, count=1.
REQ-040 JALR A=0x1001 off=0x10 PC=0x300 compressed_i=1 -> jump_o=1, target=0x1010, link_o=0x302.
REQ-041 flush_i in same cycle as executed_o & mispredicted_i -> no redirect, count unchanged; state RUN next cycle.
REQ-042 Back-to-back accepts with stall_i=1 for 3 cycles between -> exactly two single-cycle executed_o pulses.
REQ-043 count preloaded to 0xFFFF via 65535 mispredicts, one more -> stays 0xFFFF; rst_n_i low mid-REDIRECT -> redirect_o drops asynchronously.
